// File: rtl/mult_div_unit_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam logic [MD_CNT_W-1:0] MD_LAST_CNT = MD_CNT_W'(MD_WIDTH - 1);
    localparam logic [MD_WIDTH-1:0] MD_DIV0_QUO = '1;

endpackage

// File: rtl/mult_div_unit_conditional_negate.sv
// Two's-complement negation of a value when requested, otherwise pass-through.
module conditional_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO, one bit per cycle.
// state   | meaning
// ST_IDLE | waiting for start; mthi/mtlo accepted; done pulses here after a result
// ST_RUN  | one shift-add or restoring-divide iteration per edge, N edges total
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          Op,
    input  logic [MD_WIDTH-1:0] OperandA,
    input  logic [MD_WIDTH-1:0] OperandB,
    input  logic                WriteHI,
    input  logic                WriteLO,
    input  logic [MD_WIDTH-1:0] WriteData,
    output logic                busy,
    output logic                done,
    output logic [MD_WIDTH-1:0] HI,
    output logic [MD_WIDTH-1:0] LO
);

    localparam int N = MD_WIDTH;

    md_state_e              state_q;
    logic [MD_CNT_W-1:0]    cnt_q;
    logic                   is_div_q;
    logic                   neg_q;
    logic                   neg_rem_q;
    logic                   div0_q;
    logic [N-1:0]           a_raw_q;
    logic [N-1:0]           b_q;
    logic [2*N-1:0]         acc_q;
    logic [N-1:0]           hi_q;
    logic [N-1:0]           lo_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   is_signed;
    logic                   sign_a;
    logic                   sign_b;
    logic [N-1:0]           mag_a;
    logic [N-1:0]           mag_b;
    logic [N:0]             mul_sum;
    logic [2*N-1:0]         mul_d;
    logic [N:0]             div_shift;
    logic [N:0]             div_diff;
    logic [2*N-1:0]         div_d;
    logic [2*N-1:0]         prod_res;
    logic [N-1:0]           quo_res;
    logic [N-1:0]           rem_res;

    assign is_signed = (Op == MD_MULT) || (Op == MD_DIV);
    assign sign_a    = is_signed & OperandA[N-1];
    assign sign_b    = is_signed & OperandB[N-1];

    conditional_negate #(.WIDTH(N)) u_neg_a (.value(OperandA), .negate(sign_a), .result(mag_a));
    conditional_negate #(.WIDTH(N)) u_neg_b (.value(OperandB), .negate(sign_b), .result(mag_b));

    // acc_q = {partial product high, remaining multiplier bits}
    assign mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
    assign mul_d   = {mul_sum, acc_q[N-1:1]};

    // acc_q = {partial remainder, dividend bits shifting into quotient bits}
    assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_d     = div_diff[N] ? {div_shift[N-1:0], acc_q[N-2:0], 1'b0}
                                   : {div_diff[N-1:0],  acc_q[N-2:0], 1'b1};

    conditional_negate #(.WIDTH(2*N)) u_neg_prod (.value(mul_d), .negate(neg_q), .result(prod_res));
    conditional_negate #(.WIDTH(N)) u_neg_quo (.value(div_d[N-1:0]), .negate(neg_q), .result(quo_res));
    conditional_negate #(.WIDTH(N)) u_neg_rem (.value(div_d[2*N-1:N]), .negate(neg_rem_q), .result(rem_res));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_raw_q   <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (WriteHI) hi_q <= WriteData;
                    if (WriteLO) lo_q <= WriteData;
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        is_div_q  <= Op[1];
                        neg_q     <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        div0_q    <= (OperandB == '0);
                        a_raw_q   <= OperandA;
                        // multiply adds the multiplicand; divide subtracts the divisor
                        b_q       <= Op[1] ? mag_b : mag_a;
                        acc_q     <= {{N{1'b0}}, (Op[1] ? mag_a : mag_b)};
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= is_div_q ? div_d : mul_d;
                    if (cnt_q == MD_LAST_CNT) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (!is_div_q) begin
                            {hi_q, lo_q} <= prod_res;
                        end else if (div0_q) begin
                            hi_q <= a_raw_q;
                            lo_q <= MD_DIV0_QUO;
                        end else begin
                            hi_q <= rem_res;
                            lo_q <= quo_res;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed HI/LO and timing checks.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] OperandA = '0;
    logic [31:0] OperandB = '0;
    logic        WriteHI = 1'b0;
    logic        WriteLO = 1'b0;
    logic [31:0] WriteData = '0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .WriteHI(WriteHI), .WriteLO(WriteLO), .WriteData(WriteData),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op, waits (bounded) for done; optionally disturbs it with
    // start + mthi while busy, sampling HI one cycle after the disturbance.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int disturb, output int cyc, output int busy_cyc,
                          output logic [31:0] hi_mid);
        Op = op; OperandA = a; OperandB = b; start = 1'b1;
        tick();
        start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0;
        cyc = 0; busy_cyc = 0; hi_mid = '0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cyc++;
            if (cyc == disturb + 1) hi_mid = HI;
            if (cyc == disturb) begin
                start = 1'b1; Op = 2'b00; OperandA = 32'h55; OperandB = 32'h3;
                WriteHI = 1'b1; WriteData = 32'hAAAA5555;
            end
            tick();
            cyc++;
            start = 1'b0; WriteHI = 1'b0;
        end
    endtask

    int          cyc;
    int          bcyc;
    int          done_seen;
    logic [31:0] hmid;

    initial begin
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        reset = 1'b1;
        tick();

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -5, cyc, bcyc, hmid);
        chk("multu_max_hi", HI, 32'hFFFFFFFE);
        chk("multu_max_lo", LO, 32'h00000001);
        chk("multu_latency", cyc, 32);
        chk("multu_busy_cycles", bcyc, 32);
        tick();
        chk("done_falls", {31'b0, done}, 32'd0);

        WriteHI = 1'b1; WriteData = 32'h12345678;
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, -5, cyc, bcyc, hmid);
        chk("mult_neg_hi", HI, 32'hFFFFFFFF);
        chk("mult_neg_lo", LO, 32'hFFFFFFEB);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, -5, cyc, bcyc, hmid);
        chk("div_neg_lo", LO, 32'hFFFFFFFD);
        chk("div_neg_hi", HI, 32'hFFFFFFFF);

        run_op(2'b11, 32'd100, 32'd7, -5, cyc, bcyc, hmid);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);
        run_op(2'b11, 32'h1234, 32'h0, -5, cyc, bcyc, hmid);
        chk("b2b_latency", cyc, 32);
        chk("div0_hi", HI, 32'h1234);
        chk("div0_lo", LO, 32'hFFFFFFFF);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -5, cyc, bcyc, hmid);
        chk("div_ovf_lo", LO, 32'h80000000);
        chk("div_ovf_hi", HI, 32'h0);

        run_op(2'b01, 32'd6, 32'd7, 5, cyc, bcyc, hmid);
        chk("busy_write_ignored", hmid, 32'h0);
        chk("busy_start_latency", cyc, 32);
        chk("busy_start_hi", HI, 32'h0);
        chk("busy_start_lo", LO, 32'd42);

        WriteHI = 1'b1; WriteData = 32'h11;
        tick();
        WriteHI = 1'b0; WriteLO = 1'b1; WriteData = 32'h22;
        chk("mthi", HI, 32'h11);
        tick();
        WriteLO = 1'b0;
        chk("mtlo", LO, 32'h22);
        chk("mtlo_hi_kept", HI, 32'h11);

        Op = 2'b00; OperandA = 32'd5; OperandB = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_hi", HI, 32'h0);
        chk("mid_rst_lo", LO, 32'h0);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        chk("no_done_after_rst", done_seen, 0);
        chk("hi_after_rst", HI, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative MIPS multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file: its operands come straight from ReadData1/ReadData2, and it executes MULT, MULTU, DIV and DIVU over N cycles. HI/LO are read back through mfhi/mflo and written by mthi/mtlo. The pipeline control stalls on `busy`.

## Interface
- N, 32, operand width; HI and LO are each N bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state).
- start  in  1  one-cycle request; sampled only while busy==0.
- Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  in  N  rs value (ReadData1); multiplicand / dividend.
- OperandB  in  N  rt value (ReadData2); multiplier / divisor.
- WriteHI  in  1  mthi strobe; loads HI from WriteData.
- WriteLO  in  1  mtlo strobe; loads LO from WriteData.
- WriteData  in  N  rs value for mthi/mtlo.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO hold a new result.
- HI  out  N  product high word / remainder.
- LO  out  N  product low word / quotient.

## Operation
- States: IDLE and RUN. A DONE pulse is asserted for one cycle on return to IDLE.
- IDLE with start=1: capture Op, the operand magnitudes and the result signs, clear the 6-bit counter, then go to RUN.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes (two's-complement negate if MSB=1).
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB; remainder sign = signA.
  - Unsigned ops force both signs to 0.
- Multiply: shift-add, one multiplier bit per cycle, with a 2N-bit accumulator.
- Divide: restoring division, one quotient bit per cycle.
- Final result: conditionally negated combinationally, then loaded into {HI,LO} on the last RUN edge.
- Divide by zero (OperandB==0), any signedness: HI = original OperandA, LO = all ones. Latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude path.
- WriteHI/WriteLO while busy=1: ignored.
- start while busy=1: ignored.
- Same edge as start in IDLE: WriteHI/WriteLO take effect, and the result overwrites them on completion.
- If WriteHI and WriteLO are both asserted, both registers load WriteData.

## Timing
- Reset values: busy=0, done=0, HI=0, LO=0; internal state IDLE, counter 0.
- Let E0 be the edge that samples start=1.
- busy=1 from after E0 through after E(N-1).
- Edges E1..EN each perform one iteration.
- EN loads HI/LO and sets busy=0, done=1.
- done falls after E(N+1). HI/LO are valid N cycles after E0; for N=32 that is 32 cycles.
- Back-to-back: start may be sampled at E(N+1), i.e. in the cycle where done=1.
- Reset asserted mid-operation: all outputs return to reset values immediately; the operation is abandoned and no done pulse follows.
- HI/LO change only on reset, on EN, or on an accepted WriteHI/WriteLO edge.

## Structure
- Shared constants file holds:
  - Op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU.
  - Counter width.
  - The divide-by-zero quotient constant.
- Sub-module `conditional_negate` (parameter width, inputs value and negate, output result). It is instantiated for:
  - operand magnitudes (×2, N bits);
  - the product (2N bits);
  - quotient and remainder (N bits each).
- Top level contains the FSM, counter, accumulator/remainder registers and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly 32 cycles after the start edge; busy high 32 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7, followed directly by a second start in the done cycle -> LO=14, HI=2; second op accepted.
- DIVU 0x1234 / 0 -> HI=0x1234, LO=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start during busy with different operands -> ignored, first result unchanged.
- WriteHI=0xAAAA5555 while busy -> HI unchanged.
- Reset low at cycle 10 of a MULT -> busy=0, done=0, HI=LO=0 immediately; no done pulse afterward.
- mthi 0x11 then mtlo 0x22 while idle -> HI=0x11, LO=0x22 on the following edges.
